pipe_ctrl_unit: RTL and testbench

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

---
 rtl/pipe_ctrl_unit.sv | 180 ++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: ID-stage decode, hazard/stall control and the ID/EX control register
module pipe_ctrl_unit #(
    parameter int RA_W     = 4,
    parameter int FWD_EN   = 0,
    parameter int MEM_WAIT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [3:0]      cond,
    input  logic [1:0]      mode,
    input  logic [3:0]      opCode,
    input  logic            s,
    input  logic            i,
    input  logic [RA_W-1:0] rn,
    input  logic [RA_W-1:0] rm,
    input  logic [RA_W-1:0] rd,
    input  logic [3:0]      status_nzcv,
    output logic            ex_valid,
    output logic            ex_WB_EN,
    output logic            ex_MEM_R_EN,
    output logic            ex_MEM_W_EN,
    output logic            ex_B,
    output logic            ex_S,
    output logic            ex_Imm,
    output logic [3:0]      ex_EXE_CMD,
    output logic [RA_W-1:0] ex_dest,
    output logic            stall,
    output logic            flush
);
    typedef struct packed {
        logic            valid;
        logic            wb;
        logic            mr;
        logic            mw;
        logic            b;
        logic            s;
        logic            imm;
        logic [3:0]      cmd;
        logic [RA_W-1:0] dest;
    } ctl_t;

    typedef enum logic {RUN, HOLD} state_t;

    state_t          state, state_nx;
    logic [3:0]      cnt, cnt_nx;
    ctl_t            ex_q, ex_nx, dec;
    logic            mem_valid, mem_wb;
    logic [RA_W-1:0] mem_dest;
    logic            n, z, c, v;
    logic            use_rn, use_rm, use_rd, cmp_tst;
    logic            cond_ok, hit_ex, hit_mem, data_haz, flag_haz, haz, issue;

    assign {n, z, c, v} = status_nzcv;
    assign {ex_valid, ex_WB_EN, ex_MEM_R_EN, ex_MEM_W_EN, ex_B, ex_S, ex_Imm, ex_EXE_CMD, ex_dest} = ex_q;
    assign cmp_tst = opCode == 4'd10 || opCode == 4'd8;
    assign use_rn = !(mode == 2'd2 || (mode == 2'd0 && (opCode == 4'd13 || opCode == 4'd15)));
    assign use_rm = mode == 2'd0 && !i;
    assign use_rd = mode == 2'd1 && !s;

    // Decode the IF/ID instruction into EX controls; unknown opcodes and mode 3 become a valid NOP
    always_comb begin
        dec = '0;
        dec.valid = 1'b1;
        case (mode)
            2'd0: begin
                case (opCode)
                    4'd13:   dec.cmd = 4'd1;
                    4'd15:   dec.cmd = 4'd9;
                    4'd4:    dec.cmd = 4'd2;
                    4'd5:    dec.cmd = 4'd3;
                    4'd2:    dec.cmd = 4'd4;
                    4'd6:    dec.cmd = 4'd5;
                    4'd0:    dec.cmd = 4'd6;
                    4'd12:   dec.cmd = 4'd7;
                    4'd1:    dec.cmd = 4'd8;
                    4'd10:   dec.cmd = 4'd4;
                    4'd8:    dec.cmd = 4'd6;
                    default: dec.cmd = 4'd0;
                endcase
                if (dec.cmd != 4'd0) begin
                    dec.wb   = !cmp_tst;
                    dec.s    = cmp_tst | s;
                    dec.imm  = i;
                    dec.dest = rd;
                end
            end
            2'd1: begin
                dec.cmd  = 4'd2;
                dec.s    = s;
                dec.imm  = 1'b1;
                dec.wb   = s;
                dec.mr   = s;
                dec.mw   = !s;
                dec.dest = rd;
            end
            2'd2: begin
                dec.b   = 1'b1;
                dec.imm = 1'b1;
            end
            default: ;
        endcase
    end

    // Evaluate the ARM condition code against the current flags
    always_comb begin
        case (cond)
            4'd0:    cond_ok = z;
            4'd1:    cond_ok = !z;
            4'd2:    cond_ok = c;
            4'd3:    cond_ok = !c;
            4'd4:    cond_ok = n;
            4'd5:    cond_ok = !n;
            4'd6:    cond_ok = v;
            4'd7:    cond_ok = !v;
            4'd8:    cond_ok = c && !z;
            4'd9:    cond_ok = !c || z;
            4'd10:   cond_ok = n == v;
            4'd11:   cond_ok = n != v;
            4'd12:   cond_ok = !z && n == v;
            4'd13:   cond_ok = z || n != v;
            4'd14:   cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    assign hit_ex   = (use_rn && rn == ex_dest) || (use_rm && rm == ex_dest) || (use_rd && rd == ex_dest);
    assign hit_mem  = (use_rn && rn == mem_dest) || (use_rm && rm == mem_dest) || (use_rd && rd == mem_dest);
    assign data_haz = FWD_EN != 0 ? ex_valid && ex_MEM_R_EN && hit_ex
                                  : (ex_valid && ex_WB_EN && hit_ex) || (mem_valid && mem_wb && hit_mem);
    assign flag_haz = cond != 4'd14 && ex_valid && ex_S;
    assign haz      = in_valid && (data_haz || flag_haz);
    assign flush    = ex_valid && ex_B;

    // FSM state register: RUN/HOLD plus the remaining memory-wait count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // FSM next state: a memory op entering EX starts a hold that ends once the count reaches 1
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == HOLD) begin
            cnt_nx   = cnt - 4'd1;
            state_nx = cnt == 4'd1 ? RUN : HOLD;
        end else if (issue && mode == 2'd1 && MEM_WAIT != 0) begin
            cnt_nx   = 4'(MEM_WAIT);
            state_nx = HOLD;
        end
    end

    // FSM outputs: flush beats hold, hold beats hazards, otherwise issue decode or bubble
    always_comb begin
        stall = !flush && (state == HOLD || haz);
        issue = state == RUN && !flush && !haz && in_valid && cond_ok;
        ex_nx = (state == HOLD && !flush) ? ex_q : (issue ? dec : '0);
    end

    // ID/EX and MEM pipeline registers; MEM takes a bubble while EX is held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q      <= '0;
            mem_valid <= 1'b0;
            mem_wb    <= 1'b0;
            mem_dest  <= '0;
        end else begin
            ex_q      <= ex_nx;
            mem_valid <= state == HOLD ? 1'b0 : ex_valid;
            mem_wb    <= state == HOLD ? 1'b0 : ex_WB_EN;
            mem_dest  <= state == HOLD ? '0 : ex_dest;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: three configurations (plain, forwarding, MEM_WAIT=3) checked against a behavioural model
module tb_pipe_ctrl_unit;
    typedef struct packed {
        logic       valid;
        logic       wb;
        logic       mr;
        logic       mw;
        logic       b;
        logic       s;
        logic       imm;
        logic [3:0] cmd;
        logic [3:0] dest;
    } ctl_t;

    localparam logic [3:0] CMD_TAB [16] = '{4'd6, 4'd8, 4'd4, 4'd0, 4'd2, 4'd3, 4'd5, 4'd0,
                                           4'd6, 4'd0, 4'd4, 4'd0, 4'd7, 4'd1, 4'd0, 4'd9};

    logic       clk, rst, in_valid, sb, ib;
    logic [3:0] cond, opc, rn, rm, rd, nzcv;
    logic [1:0] mode;
    ctl_t       o_ex [3];
    logic       o_stall [3];
    logic       o_flush [3];
    int         n_tests = 0;
    int         n_fail  = 0;

    ctl_t       m_ex  [3];
    logic       m_mv  [3];
    logic       m_mwb [3];
    logic [3:0] m_md  [3];
    int         m_hold [3];

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        logic       v, wb, mr, mw, b, sf, imm, st, fl;
        logic [3:0] cmd, dst;
        pipe_ctrl_unit #(.RA_W(4), .FWD_EN(g == 1 ? 1 : 0), .MEM_WAIT(g == 2 ? 3 : 0)) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .cond(cond), .mode(mode), .opCode(opc),
            .s(sb), .i(ib), .rn(rn), .rm(rm), .rd(rd), .status_nzcv(nzcv),
            .ex_valid(v), .ex_WB_EN(wb), .ex_MEM_R_EN(mr), .ex_MEM_W_EN(mw), .ex_B(b), .ex_S(sf),
            .ex_Imm(imm), .ex_EXE_CMD(cmd), .ex_dest(dst), .stall(st), .flush(fl));
        assign o_ex[g]    = {v, wb, mr, mw, b, sf, imm, cmd, dst};
        assign o_stall[g] = st;
        assign o_flush[g] = fl;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t decode();
        ctl_t d = '0;
        d.valid = 1'b1;
        if (mode == 2'd0 && CMD_TAB[opc] != 4'd0) begin
            d.cmd  = CMD_TAB[opc];
            d.s    = sb || opc == 4'd10 || opc == 4'd8;
            d.wb   = !(opc == 4'd10 || opc == 4'd8);
            d.imm  = ib;
            d.dest = rd;
        end else if (mode == 2'd1) begin
            d.cmd  = 4'd2;
            d.s    = sb;
            d.imm  = 1'b1;
            d.wb   = sb;
            d.mr   = sb;
            d.mw   = !sb;
            d.dest = rd;
        end else if (mode == 2'd2) begin
            d.b   = 1'b1;
            d.imm = 1'b1;
        end
        return d;
    endfunction

    function automatic bit cond_true();
        bit n = nzcv[3], z = nzcv[2], c = nzcv[1], v = nzcv[0];
        bit base;
        int pair = int'(cond) / 2;
        if (cond == 4'd14) return 1'b1;
        if (cond == 4'd15) return 1'b0;
        base = pair == 0 ? z : pair == 1 ? c : pair == 2 ? n : pair == 3 ? v :
               pair == 4 ? (c && !z) : pair == 5 ? (n == v) : (!z && n == v);
        return base ^ cond[0];
    endfunction

    function automatic bit uses(input logic [3:0] r);
        bit rn_used = !(mode == 2'd2 || (mode == 2'd0 && (opc == 4'd13 || opc == 4'd15)));
        return (rn_used && rn == r) || (mode == 2'd0 && !ib && rm == r) || (mode == 2'd1 && !sb && rd == r);
    endfunction

    function automatic bit hazard(input int k);
        bit dh;
        if (k == 1) dh = m_ex[k].valid && m_ex[k].mr && uses(m_ex[k].dest);
        else dh = (m_ex[k].valid && m_ex[k].wb && uses(m_ex[k].dest)) || (m_mv[k] && m_mwb[k] && uses(m_md[k]));
        return in_valid && (dh || (cond != 4'd14 && m_ex[k].valid && m_ex[k].s));
    endfunction

    function automatic bit e_flush(input int k);
        return m_ex[k].valid && m_ex[k].b;
    endfunction

    function automatic bit e_stall(input int k);
        return !e_flush(k) && (m_hold[k] > 0 || hazard(k));
    endfunction

    function automatic ctl_t nx_ex(input int k);
        if (e_flush(k)) return '0;
        if (m_hold[k] > 0) return m_ex[k];
        if (hazard(k) || !in_valid || !cond_true()) return '0;
        return decode();
    endfunction

    function automatic int nx_hold(input int k);
        ctl_t nx = nx_ex(k);
        if (m_hold[k] > 0) return m_hold[k] - 1;
        return (k == 2 && (nx.mr || nx.mw)) ? 3 : 0;
    endfunction

    // Reference model: pipeline contents plus remaining wait cycles per configuration
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                m_ex[k]   <= '0;
                m_mv[k]   <= 1'b0;
                m_mwb[k]  <= 1'b0;
                m_md[k]   <= '0;
                m_hold[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                m_ex[k]   <= nx_ex(k);
                m_hold[k] <= nx_hold(k);
                m_mv[k]   <= m_hold[k] == 0 && m_ex[k].valid;
                m_mwb[k]  <= m_hold[k] == 0 && m_ex[k].wb;
                m_md[k]   <= m_hold[k] == 0 ? m_ex[k].dest : 4'd0;
            end
        end
    end

    task automatic lit(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (o_ex[k] !== m_ex[k] || o_stall[k] !== e_stall(k) || o_flush[k] !== e_flush(k)) begin
                n_fail++;
                $display("FAIL model cfg%0d at %0t: ex=%h stall=%b flush=%b, expected ex=%h stall=%b flush=%b",
                         k, $time, o_ex[k], o_stall[k], o_flush[k], m_ex[k], e_stall(k), e_flush(k));
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #2;
    endtask

    task automatic ins(input logic [1:0] md, input logic [3:0] op, input logic [3:0] cd, input bit s_, input bit i_,
                       input logic [3:0] a_rn, input logic [3:0] a_rm, input logic [3:0] a_rd);
        in_valid = 1'b1;
        mode = md; opc = op; cond = cd; sb = s_; ib = i_; rn = a_rn; rm = a_rm; rd = a_rd;
    endtask

    task automatic idle(input int cyc);
        in_valid = 1'b0;
        repeat (cyc) begin
            chk();
            adv();
        end
    endtask

    task automatic rand_ins();
        in_valid = $urandom_range(0, 9) != 0;
        cond = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'd14;
        mode = 2'($urandom_range(0, 3));
        opc  = 4'($urandom_range(0, 15));
        sb   = 1'($urandom_range(0, 1));
        ib   = 1'($urandom_range(0, 1));
        rn   = 4'($urandom_range(0, 3));
        rm   = 4'($urandom_range(0, 3));
        rd   = 4'($urandom_range(0, 3));
        nzcv = 4'($urandom_range(0, 15));
    endtask

    logic [1:0]  t_md [3] = '{2'd3, 2'd0, 2'd0};
    logic [3:0]  t_op [3] = '{4'd4, 4'd4, 4'd3};
    logic [3:0]  t_cd [3] = '{4'd14, 4'd15, 4'd14};
    logic [14:0] t_ex [3] = '{15'h4000, 15'h0000, 15'h4000};

    initial begin
        rst = 1'b0; in_valid = 1'b0; nzcv = 4'd0;
        ins(2'd0, 4'd0, 4'd14, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        in_valid = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            lit("reset ex", 16'(o_ex[k]), 16'h0);
            lit("reset stall/flush", {14'd0, o_stall[k], o_flush[k]}, 16'h0);
        end
        adv();
        rst = 1'b1;
        // ADD r1 then SUB reading r1
        ins(2'd0, 4'd4, 4'd14, 1'b0, 1'b1, 4'd5, 4'd0, 4'd1);
        chk(); adv();
        ins(2'd0, 4'd2, 4'd14, 1'b0, 1'b1, 4'd1, 4'd0, 4'd6);
        chk(); lit("raw stall c1", 16'(o_stall[0]), 16'd1); lit("fwd no stall", 16'(o_stall[1]), 16'd0); adv();
        chk(); lit("raw stall c2", 16'(o_stall[0]), 16'd1); adv();
        chk(); lit("raw stall c3", 16'(o_stall[0]), 16'd0); adv();
        in_valid = 1'b0;
        chk(); lit("sub issued cmd", 16'(o_ex[0].cmd), 16'd4); lit("sub issued valid", 16'(o_ex[0].valid), 16'd1); adv();
        // LDR r2 then ADD reading r2 with forwarding
        ins(2'd1, 4'd0, 4'd14, 1'b1, 1'b0, 4'd7, 4'd0, 4'd2);
        chk(); adv();
        ins(2'd0, 4'd4, 4'd14, 1'b0, 1'b1, 4'd2, 4'd0, 4'd3);
        chk(); lit("load-use stall", 16'(o_stall[1]), 16'd1); adv();
        chk(); lit("load-use cleared", 16'(o_stall[1]), 16'd0); adv();
        in_valid = 1'b0;
        chk(); lit("add after ldr", 16'(o_ex[1].cmd), 16'd2); adv();
        idle(5);
        // Unconditional branch flushes the instruction behind it
        ins(2'd2, 4'd0, 4'd14, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        chk(); adv();
        ins(2'd0, 4'd4, 4'd14, 1'b0, 1'b1, 4'd0, 4'd0, 4'd5);
        chk(); lit("branch ex_B", 16'(o_ex[0].b), 16'd1); lit("branch flush", 16'(o_flush[0]), 16'd1);
        lit("flush no stall", 16'(o_stall[0]), 16'd0); adv();
        in_valid = 1'b0;
        chk(); lit("flushed bubble", 16'(o_ex[0].valid), 16'd0); adv();
        idle(2);
        // CMP then BEQ, taken and not taken
        for (int t = 0; t < 2; t++) begin
            nzcv = t == 0 ? 4'b0100 : 4'b0000;
            ins(2'd0, 4'd10, 4'd14, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0);
            chk(); adv();
            ins(2'd2, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
            chk(); lit("flag stall", 16'(o_stall[0]), 16'd1); adv();
            chk(); lit("flag stall cleared", 16'(o_stall[0]), 16'd0); adv();
            in_valid = 1'b0;
            chk(); lit(t == 0 ? "beq taken" : "beq not taken", 16'(o_ex[0].b), t == 0 ? 16'd1 : 16'd0); adv();
            idle(2);
        end
        // STR with MEM_WAIT=3
        ins(2'd1, 4'd0, 4'd14, 1'b0, 1'b0, 4'd8, 4'd0, 4'd9);
        chk(); adv();
        in_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk();
            lit("str mem_w held", 16'(o_ex[2].mw), c <= 4 ? 16'd1 : 16'd0);
            lit("str stall", 16'(o_stall[2]), c <= 3 ? 16'd1 : 16'd0);
            adv();
        end
        idle(2);
        // Reset in the second hold cycle
        ins(2'd1, 4'd0, 4'd14, 1'b0, 1'b0, 4'd8, 4'd0, 4'd9);
        chk(); adv();
        in_valid = 1'b0;
        chk(); adv();
        #1 rst = 1'b0;
        #1;
        lit("async reset ex", 16'(o_ex[2]), 16'h0);
        lit("async reset stall", 16'(o_stall[2]), 16'h0);
        rst = 1'b1;
        ins(2'd0, 4'd4, 4'd14, 1'b0, 1'b1, 4'd0, 4'd0, 4'd3);
        chk(); adv();
        in_valid = 1'b0;
        chk(); lit("post-reset issue", {8'd0, o_ex[2].valid, o_stall[2], 2'd0, o_ex[2].cmd}, 16'h0082); adv();
        // NOP / never / unlisted opcode
        for (int t = 0; t < 3; t++) begin
            ins(t_md[t], t_op[t], t_cd[t], 1'b1, 1'b1, 4'd0, 4'd0, 4'd1);
            chk(); adv();
            in_valid = 1'b0;
            chk(); lit("nop decode", 16'(o_ex[0]), 16'(t_ex[t])); adv();
        end
        // Randomized traffic, sometimes holding IF/ID while stalled
        for (int c = 0; c < 3000; c++) begin
            if (!(o_stall[0] && $urandom_range(0, 1) == 1)) rand_ins();
            chk();
            adv();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
